// File: rtl/voting_tally_sequencer.sv
// voting_tally_sequencer: serial ballot collector, tally walker and plurality winner selector.
// Optional tie output is enabled with `define VOTE_SCHED_TIE_EN.
module voting_tally_sequencer #(
  parameter int NUM_VOTERS = 16,
  parameter int CAND_W = 2,
  localparam int IW = $clog2(NUM_VOTERS),
  localparam int CW = $clog2(NUM_VOTERS + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ballot_valid,
  output logic              ballot_ready,
  input  logic [IW-1:0]     ballot_id,
  input  logic [CAND_W-1:0] ballot_val,
  input  logic              close_req,
  output logic              busy,
  output logic              dup_err,
  output logic              result_valid,
  input  logic              result_ready,
  output logic [CAND_W-1:0] winner,
  output logic [CW-1:0]     win_count
`ifdef VOTE_SCHED_TIE_EN
  ,
  output logic              tie
`endif
);
  localparam int NC = 2 ** CAND_W;
  typedef enum logic [1:0] {COLLECT, TALLY, COMPARE, OUTPUT} state_t;
  state_t state_q, state_d;
  logic [NUM_VOTERS-1:0] present_q, present_d;
  logic [NUM_VOTERS-1:0][CAND_W-1:0] slot_q, slot_d;
  logic [NC-1:0][CW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [CAND_W-1:0] c_q, c_d, best_q, best_d, winner_q, winner_d;
  logic [CW-1:0] best_cnt_q, best_cnt_d, win_count_q, win_count_d;
  logic ballot_ready_q, ballot_ready_d, busy_q, busy_d;
  logic dup_err_q, dup_err_d, result_valid_q, result_valid_d;
  logic accept, take;
`ifdef VOTE_SCHED_TIE_EN
  logic tie_acc_q, tie_acc_d, tie_q, tie_d;
  assign tie = tie_q;
`endif
  assign accept = ballot_valid && ballot_ready_q;
  // candidate 0 always seeds best; later ones must be strictly greater
  assign take = (c_q == '0) || (cnt_q[c_q] > best_cnt_q);
  assign ballot_ready = ballot_ready_q;
  assign busy = busy_q;
  assign dup_err = dup_err_q;
  assign result_valid = result_valid_q;
  assign winner = winner_q;
  assign win_count = win_count_q;
  always_comb begin
    state_d = state_q;
    present_d = present_q;
    slot_d = slot_q;
    cnt_d = cnt_q;
    idx_d = idx_q;
    c_d = c_q;
    best_d = best_q;
    best_cnt_d = best_cnt_q;
    winner_d = winner_q;
    win_count_d = win_count_q;
    dup_err_d = 1'b0;
`ifdef VOTE_SCHED_TIE_EN
    tie_acc_d = tie_acc_q;
    tie_d = tie_q;
`endif
    case (state_q)
      COLLECT: begin
        if (accept) begin
          dup_err_d = present_q[ballot_id];
          present_d[ballot_id] = 1'b1;
          slot_d[ballot_id] = present_q[ballot_id] ? slot_q[ballot_id] : ballot_val;
        end
        if (close_req) begin
          state_d = TALLY;
          cnt_d = '0;
          idx_d = '0;
        end
      end
      TALLY: begin
        cnt_d[slot_q[idx_q]] = cnt_q[slot_q[idx_q]] + CW'(present_q[idx_q]);
        idx_d = idx_q + 1'b1;
        if (idx_q == IW'(NUM_VOTERS - 1)) begin
          state_d = COMPARE;
          c_d = '0;
        end
      end
      COMPARE: begin
        best_d = take ? c_q : best_q;
        best_cnt_d = take ? cnt_q[c_q] : best_cnt_q;
`ifdef VOTE_SCHED_TIE_EN
        tie_acc_d = !take && (tie_acc_q || cnt_q[c_q] == best_cnt_q);
`endif
        c_d = c_q + 1'b1;
        if (c_q == '1) begin
          state_d = OUTPUT;
          winner_d = best_d;
          win_count_d = best_cnt_d;
`ifdef VOTE_SCHED_TIE_EN
          tie_d = tie_acc_d;
`endif
        end
      end
      OUTPUT: begin
        if (result_ready) begin
          present_d = '0;
          state_d = COLLECT;
        end
      end
      default: state_d = COLLECT;
    endcase
    ballot_ready_d = state_d == COLLECT;
    busy_d = (state_d == TALLY) || (state_d == COMPARE);
    result_valid_d = state_d == OUTPUT;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= COLLECT;
      present_q <= '0;
      slot_q <= '0;
      cnt_q <= '0;
      idx_q <= '0;
      c_q <= '0;
      best_q <= '0;
      best_cnt_q <= '0;
      winner_q <= '0;
      win_count_q <= '0;
      ballot_ready_q <= 1'b1;
      busy_q <= 1'b0;
      dup_err_q <= 1'b0;
      result_valid_q <= 1'b0;
`ifdef VOTE_SCHED_TIE_EN
      tie_acc_q <= 1'b0;
      tie_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      present_q <= present_d;
      slot_q <= slot_d;
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      c_q <= c_d;
      best_q <= best_d;
      best_cnt_q <= best_cnt_d;
      winner_q <= winner_d;
      win_count_q <= win_count_d;
      ballot_ready_q <= ballot_ready_d;
      busy_q <= busy_d;
      dup_err_q <= dup_err_d;
      result_valid_q <= result_valid_d;
`ifdef VOTE_SCHED_TIE_EN
      tie_acc_q <= tie_acc_d;
      tie_q <= tie_d;
`endif
    end
  end
endmodule

// File: tb/tb_voting_tally_sequencer.sv
// tb_voting_tally_sequencer: directed polls; expected results queued at close, checked by a monitor.
module tb_voting_tally_sequencer;
  logic clk = 1'b0, rst_n = 1'b0, ballot_valid = 1'b0, close_req = 1'b0, result_ready = 1'b0;
  logic [3:0] ballot_id = '0;
  logic [1:0] ballot_val = '0;
  logic ballot_ready, busy, dup_err, result_valid, tie;
  logic [1:0] winner;
  logic [4:0] win_count;
  typedef struct { logic [1:0] w; logic [4:0] n; logic t; int cyc; } exp_t;
  exp_t sb[$];
  exp_t cur;
  bit active = 0;
  int cyc = 0, n_chk = 0, n_fail = 0, dup_cnt = 0, dup_base = 0;
  int v1[16] = '{1, 1, 1, 1, 1, 2, 2, 2, 2, 3, 0, 0, 0, 0, 0, 1};

  voting_tally_sequencer dut (
    .clk(clk), .rst_n(rst_n), .ballot_valid(ballot_valid), .ballot_ready(ballot_ready),
    .ballot_id(ballot_id), .ballot_val(ballot_val), .close_req(close_req), .busy(busy),
    .dup_err(dup_err), .result_valid(result_valid), .result_ready(result_ready),
    .winner(winner), .win_count(win_count)
`ifdef VOTE_SCHED_TIE_EN
    , .tie(tie)
`endif
  );
`ifndef VOTE_SCHED_TIE_EN
  assign tie = 1'b0;
`endif

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic ballot(input int id, input int val);
    ballot_valid = 1'b1;
    ballot_id = 4'(id);
    ballot_val = 2'(val);
    step();
    ballot_valid = 1'b0;
  endtask

  task automatic close_poll(input logic [1:0] w, input logic [4:0] n, input logic t, input bit push);
    close_req = 1'b1;
    if (push) sb.push_back('{w, n, t, cyc + 21});
    step();
    close_req = 1'b0;
    ballot_valid = 1'b0;
  endtask

  task automatic finish_poll(input int hold);
    for (int i = 0; i < 40 && !result_valid; i++) step();
    chk("result_valid_timeout", int'(result_valid), 1);
    repeat (hold) step();
    result_ready = 1'b1;
    step();
    result_ready = 1'b0;
    chk("ready_after_handshake", int'(ballot_ready), 1);
    chk("valid_after_handshake", int'(result_valid), 0);
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_ballot_ready"}, int'(ballot_ready), 1);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_dup_err"}, int'(dup_err), 0);
    chk({tag, "_result_valid"}, int'(result_valid), 0);
    chk({tag, "_winner"}, int'(winner), 0);
    chk({tag, "_win_count"}, int'(win_count), 0);
    chk({tag, "_tie"}, int'(tie), 0);
  endtask

  always @(negedge clk) begin
    if (dup_err) dup_cnt++;
    if (!result_valid) active = 0;
    else if (!active) begin
      active = 1;
      if (sb.size() == 0) chk("unexpected_result", sb.size(), 1);
      else begin
        cur = sb.pop_front();
        chk("latency_cycle", cyc, cur.cyc);
        chk("winner", int'(winner), int'(cur.w));
        chk("win_count", int'(win_count), int'(cur.n));
`ifdef VOTE_SCHED_TIE_EN
        chk("tie", int'(tie), int'(cur.t));
`endif
      end
    end else begin
      chk("winner_hold", int'(winner), int'(cur.w));
      chk("win_count_hold", int'(win_count), int'(cur.n));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    reset_checks("reset");
    rst_n = 1'b1;
    step();
    for (int i = 0; i < 16; i++) ballot(i, v1[i]);
    close_poll(2'd1, 5'd6, 1'b0, 1);
    chk("busy_in_tally", int'(busy), 1);
    chk("ready_low_in_tally", int'(ballot_ready), 0);
    finish_poll(10);
    for (int i = 0; i < 4; i++) ballot(i, 2);
    for (int i = 4; i < 8; i++) ballot(i, 1);
    close_poll(2'd1, 5'd4, 1'b1, 1);
    finish_poll(0);
    dup_base = dup_cnt;
    ballot(5, 3);
    ballot(5, 0);
    step();
    step();
    chk("dup_err_pulses", dup_cnt - dup_base, 1);
    close_poll(2'd3, 5'd1, 1'b0, 1);
    finish_poll(2);
    close_poll(2'd0, 5'd0, 1'b1, 1);
    finish_poll(1);
    for (int i = 0; i < 3; i++) ballot(i, 3);
    close_poll(2'd3, 5'd3, 1'b0, 0);
    repeat (7) step();
    chk("busy_before_reset", int'(busy), 1);
    rst_n = 1'b0;
    #1;
    reset_checks("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    step();
    ballot_valid = 1'b1;
    ballot_id = 4'd9;
    ballot_val = 2'd2;
    close_poll(2'd2, 5'd1, 1'b0, 1);
    finish_poll(0);
    chk("dup_err_total", dup_cnt, 1);
    chk("scoreboard_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
